// File: rtl/spi_cfg_scheduler.sv
// spi_cfg_scheduler
// Collects {address, data} configuration writes from an SPI byte stream into a
// small FIFO. The writes are applied to the output registers only during vertical
// blanking, one entry per cycle, so the display never sees a half-applied
// configuration.
// Optional build macro: SPI_CFG_DROPCNT_EN adds a saturating drop_count output.
//
// Parser FSM
//   state  | meaning
//   P_HDR  | waiting for the header byte of a transaction (0x00 = write)
//   P_ADDR | next byte is a register address (low nibble)
//   P_DATA | next byte is data for the latched address
//   P_SKIP | unknown header, ignore bytes until chip select goes high
//
// Drain FSM
//   state   | meaning
//   D_IDLE  | queued writes are held until the next frame_start
//   D_DRAIN | popping the snapshot of queued writes, one per cycle
module spi_cfg_scheduler #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ssel,
  input  logic       byte_valid,
  input  logic [7:0] byte_in,
  input  logic       frame_start,
  input  logic       clear_ovf,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic       audio_en,
  output logic [3:0] pending,
  output logic       busy,
  output logic       overflow
`ifdef SPI_CFG_DROPCNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {P_HDR, P_ADDR, P_DATA, P_SKIP} pstate_t;
  typedef enum logic {D_IDLE, D_DRAIN} dstate_t;

  pstate_t        r_pstate;
  dstate_t        r_dstate;
  logic [3:0]     r_addr;
  logic [9:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [3:0]     r_count;
  logic [3:0]     r_snap;
  logic [7:0]     r_bg;
  logic [5:0]     r_sc;
  logic           r_au;
  logic           r_ovf;

  logic           w_pair_vld;
  logic           w_full;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [9:0]     w_rd_entry;

  // A complete pair targeting a known register; unknown addresses vanish here.
  assign w_pair_vld = byte_valid && !ssel && (r_pstate == P_DATA) && (r_addr <= 4'd2);
  assign w_full     = (r_count == 4'(DEPTH));
  assign w_pop      = (r_dstate == D_DRAIN);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push     = w_pair_vld && (!w_full || w_pop);
  assign w_drop     = w_pair_vld && w_full && !w_pop;
  assign w_rd_entry = r_mem[r_rd_ptr];

  // Parser: ssel high aborts the transaction and drops any half pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pstate <= P_HDR;
      r_addr   <= 4'd0;
    end else if (ssel) begin
      r_pstate <= P_HDR;
    end else if (byte_valid) begin
      case (r_pstate)
        P_HDR:  r_pstate <= (byte_in == 8'h00) ? P_ADDR : P_SKIP;
        P_ADDR: begin
          r_addr   <= byte_in[3:0];
          r_pstate <= P_DATA;
        end
        P_DATA: r_pstate <= P_ADDR;
        default: r_pstate <= P_SKIP;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_addr[1:0], byte_in};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 4'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM: only the entries present at frame_start are applied this frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dstate <= D_IDLE;
      r_snap   <= 4'd0;
    end else begin
      case (r_dstate)
        D_IDLE: begin
          if (frame_start && (r_count != 4'd0)) begin
            r_snap   <= r_count;
            r_dstate <= D_DRAIN;
          end
        end
        default: begin
          r_snap <= r_snap - 4'd1;
          if (r_snap == 4'd1) r_dstate <= D_IDLE;
        end
      endcase
    end
  end

  // Apply each popped entry to its output register at the pop edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bg <= 8'd10;
      r_sc <= 6'd0;
      r_au <= 1'b0;
    end else if (w_pop) begin
      case (w_rd_entry[9:8])
        2'd0:    r_bg <= w_rd_entry[7:0];
        2'd1:    r_sc <= w_rd_entry[5:0];
        default: r_au <= w_rd_entry[0];
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

`ifdef SPI_CFG_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  // Saturating count of dropped pairs; a drop alongside a clear counts as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (clear_ovf) begin
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_count = r_drop_cnt;
`endif

  assign background_state = r_bg;
  assign solid_color      = r_sc;
  assign audio_en         = r_au;
  assign pending          = r_count;
  assign busy             = (r_dstate == D_DRAIN);
  assign overflow         = r_ovf;

endmodule

// File: doc/spi_cfg_scheduler.md
SPI_CFG_SCHEDULER -- requirements
Module: spi_cfg_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-write FIFO entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port ssel  input  1  SPI chip select level, active-low, already in the clk domain.
REQ-005 SHALL have port byte_valid  input  1  one-cycle strobe, byte_in holds a received SPI byte.
REQ-006 SHALL have port byte_in  input  8  received SPI byte, MSB first as shifted.
REQ-007 SHALL have port frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-008 SHALL have port clear_ovf  input  1  one-cycle pulse, clears overflow.
REQ-009 SHALL have port background_state  output  8  applied background mode.
REQ-010 SHALL have port solid_color  output  6  applied solid color, RRGGBB.
REQ-011 SHALL have port audio_en  output  1  applied audio enable.
REQ-012 SHALL have port pending  output  4  current FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port busy  output  1  high while in DRAIN.
REQ-014 SHALL have port overflow  output  1  sticky, a write was dropped on a full FIFO.

Function
REQ-015 Parser FSM SHALL have states HDR, ADDR, DATA, SKIP; byte_valid with ssel low advances it.
REQ-016 HDR: byte 0x00 -> ADDR; any other byte -> SKIP; SKIP ignores bytes until ssel high.
REQ-017 ADDR: latch byte_in[3:0] as address, -> DATA; DATA: form pair {addr, byte_in}, -> ADDR.
REQ-018 Pairs with address 0 (background_state), 1 (solid_color = data[5:0]) or 2 (audio_en = data[0]) SHALL be pushed; other addresses SHALL be discarded silently, never counted as overflow.
REQ-019 Push SHALL occur the cycle after the DATA byte_valid; pending increments in that same cycle.
REQ-020 ssel high in any cycle SHALL force parser to HDR, discard any half pair, leave FIFO intact; byte_valid in that cycle is ignored.
REQ-021 Push when pending == DEPTH and no pop in the same cycle SHALL drop the pair and set overflow.
REQ-022 Simultaneous push and pop SHALL both succeed, pending unchanged, even when full.
REQ-023 Drain FSM SHALL have states IDLE, DRAIN; frame_start in IDLE with pending > 0 latches snapshot count = pending and enters DRAIN.
REQ-024 DRAIN SHALL pop one entry per cycle in FIFO order, decrement the snapshot count, return to IDLE when it reaches 0; pairs pushed during DRAIN wait for the next frame_start.
REQ-025 A popped entry SHALL update its output register one cycle after the pop; later entries to the same address overwrite earlier ones.
REQ-026 frame_start during DRAIN, or with pending == 0, SHALL be ignored.
REQ-027 clear_ovf SHALL clear overflow next cycle; simultaneous clear_ovf and new drop SHALL leave overflow set.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; pending SHALL never exceed DEPTH or underflow.

Reset
REQ-029 rst SHALL set background_state = 10, solid_color = 0, audio_en = 0, pending = 0, busy = 0, overflow = 0, parser HDR, drain IDLE.
REQ-030 rst mid-DRAIN or mid-pair SHALL discard all queued and partial writes; rst overrides all other inputs.

Configuration
REQ-031 With SPI_CFG_DROPCNT_EN defined, port drop_count output 8 SHALL exist, incrementing per dropped pair, saturating at 255, cleared by rst and clear_ovf.
REQ-032 Without SPI_CFG_DROPCNT_EN, drop_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 ssel low, bytes 00,01,2A; frame_start -> solid_color = 0x2A two cycles after frame_start, pending 1 -> 0.
REQ-034 Bytes 00,00,05,00,07 then frame_start -> background_state 5 then 7 on consecutive cycles, busy high 2 cycles.
REQ-035 Header 01 then 00,05 -> nothing pushed, pending 0, outputs unchanged after frame_start.
REQ-036 DEPTH=4, five valid pairs with no frame_start -> pending 4, overflow 1, drop_count 1 (if enabled); clear_ovf -> overflow 0.
REQ-037 ssel high after 00,02 (no data byte), then new transaction 00,02,01 -> single push, audio_en = 1 after frame_start.
REQ-038 rst asserted during DRAIN with 3 queued -> all outputs at reset values, pending 0, later frame_start has no effect.
